// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks E/M/W destination tags
// with their remaining Tnew and derives stall and forward selects from Tuse vs Tnew.
module hazard_fwd_unit #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_hilo_use,
    output logic          stall,
    output logic          md_busy,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          fwd_rt_m
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] waddr;
        logic [TW-1:0] tnew;
    } dst_t;

    localparam logic [TW-1:0] TUSE_NONE = '1;
    localparam logic [1:0]    SEL_NONE  = 2'd0;
    localparam logic [1:0]    SEL_M     = 2'd1;
    localparam logic [1:0]    SEL_W     = 2'd2;
    localparam logic [1:0]    SEL_E     = 2'd3;
    localparam logic [CW-1:0] MUL_CNT   = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT   = CW'(DIV_LAT);

    dst_t          dst_e, dst_m, dst_w;
    logic [AW-1:0] rs_e, rt_e, rt_m;
    logic [CW-1:0] md_cnt;
    logic          data_stall, md_stall, md_load;

    function automatic logic hit(input dst_t t, input logic [AW-1:0] a);
        return t.valid && (t.waddr == a) && (a != '0);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // The youngest matching producer alone decides; older producers are shadowed.
    function automatic logic src_stall(input logic [AW-1:0] a, input logic [TW-1:0] tuse,
                                       input dst_t e, input dst_t m, input dst_t w);
        logic s;
        s = 1'b0;
        if (tuse != TUSE_NONE) begin
            if (hit(e, a))      s = (e.tnew > tuse);
            else if (hit(m, a)) s = (m.tnew > tuse);
            else if (hit(w, a)) s = (w.tnew > tuse);
        end
        return s;
    endfunction

    function automatic logic [1:0] sel_d(input logic [AW-1:0] a,
                                         input dst_t e, input dst_t m, input dst_t w);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (hit(e, a))      sel = (e.tnew == '0) ? SEL_E : SEL_NONE;
        else if (hit(m, a)) sel = (m.tnew == '0) ? SEL_M : SEL_NONE;
        else if (hit(w, a)) sel = (w.tnew == '0) ? SEL_W : SEL_NONE;
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(input logic [AW-1:0] a, input dst_t m, input dst_t w);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (hit(m, a))      sel = (m.tnew == '0) ? SEL_M : SEL_NONE;
        else if (hit(w, a)) sel = (w.tnew == '0) ? SEL_W : SEL_NONE;
        return sel;
    endfunction

    assign md_busy = (md_cnt != '0);

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        data_stall = d_valid && (src_stall(d_rs, d_rs_tuse, dst_e, dst_m, dst_w) ||
                                 src_stall(d_rt, d_rt_tuse, dst_e, dst_m, dst_w));
        md_stall   = d_valid && (d_md_start || d_hilo_use) && md_busy;
        stall      = data_stall || md_stall;
        md_load    = d_valid && d_md_start && !stall;
        fwd_rs_d   = sel_d(d_rs, dst_e, dst_m, dst_w);
        fwd_rt_d   = sel_d(d_rt, dst_e, dst_m, dst_w);
        fwd_rs_e   = sel_e(rs_e, dst_m, dst_w);
        fwd_rt_e   = sel_e(rt_e, dst_m, dst_w);
        fwd_rt_m   = hit(dst_w, rt_m) && (dst_w.tnew == '0);
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_e  <= '0;
            dst_m  <= '0;
            dst_w  <= '0;
            rs_e   <= '0;
            rt_e   <= '0;
            rt_m   <= '0;
            md_cnt <= '0;
        end else begin
            if (stall || !d_valid) begin
                dst_e <= '0;
                rs_e  <= '0;
                rt_e  <= '0;
            end else begin
                dst_e <= '{valid: d_wr_en, waddr: d_wr_addr, tnew: d_tnew};
                rs_e  <= d_rs;
                rt_e  <= d_rt;
            end
            dst_m <= '{valid: dst_e.valid, waddr: dst_e.waddr, tnew: dec_sat(dst_e.tnew)};
            rt_m  <= rt_e;
            dst_w <= '{valid: dst_m.valid, waddr: dst_m.waddr, tnew: dec_sat(dst_m.tnew)};

            // A start while busy is already stalled, so a load never hits a running count.
            if (md_load)            md_cnt <= d_md_div ? DIV_CNT : MUL_CNT;
            else if (md_cnt != '0)  md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios with literal
// expectations plus randomized traffic compared every cycle against an age-based model.
module tb_hazard_fwd_unit;

    localparam int AW = 5, TW = 2, MUL_LAT = 5, DIV_LAT = 10, CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          d_valid, d_wr_en, d_md_start, d_md_div, d_hilo_use;
    logic [AW-1:0] d_rs, d_rt, d_wr_addr;
    logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic          stall, md_busy, fwd_rt_m;
    logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.AW(AW), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wr_en(d_wr_en),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_hilo_use(d_hilo_use), .stall(stall), .md_busy(md_busy),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each in-flight instruction keeps the Tnew it entered E with; its current
    // Tnew is that value minus its age in stages (E=0, M=1, W=2), floored at zero.
    typedef struct { bit v; int wa; int tn; int rs; int rt; } rec_t;
    rec_t pipe[3];
    int   cyc = 0;
    int   busy_end = 0;

    function automatic int cur_tnew(int i);
        int t;
        t = pipe[i].tn - i;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int youngest(int a, int from);
        for (int i = from; i < 3; i++)
            if (pipe[i].v && pipe[i].wa == a && a != 0) return i;
        return -1;
    endfunction

    function automatic bit m_busy();
        return cyc < busy_end;
    endfunction

    function automatic bit m_stall();
        int a[2];
        int tu[2];
        bit s;
        a[0] = int'(d_rs); a[1] = int'(d_rt);
        tu[0] = int'(d_rs_tuse); tu[1] = int'(d_rt_tuse);
        s = 0;
        if (d_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (tu[k] != 3) begin
                    int i;
                    i = youngest(a[k], 0);
                    if (i >= 0 && cur_tnew(i) > tu[k]) s = 1;
                end
            end
            if ((d_md_start || d_hilo_use) && m_busy()) s = 1;
        end
        return s;
    endfunction

    function automatic int m_fwd_d(int a);
        int i;
        i = youngest(a, 0);
        if (i < 0 || cur_tnew(i) != 0) return 0;
        return (i == 0) ? 3 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic int m_fwd_e(int a);
        int i;
        i = youngest(a, 1);
        if (i < 0 || cur_tnew(i) != 0) return 0;
        return i;
    endfunction

    function automatic int m_fwd_m(int a);
        int i;
        i = youngest(a, 2);
        return (i == 2 && cur_tnew(i) == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            busy_end = cyc;
        end else begin
            bit st;
            st = m_stall();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || !d_valid) pipe[0] = '{default: 0};
            else pipe[0] = '{d_wr_en, int'(d_wr_addr), int'(d_tnew), int'(d_rs), int'(d_rt)};
            cyc++;
            if (d_valid && d_md_start && !st)
                busy_end = cyc + (d_md_div ? DIV_LAT : MUL_LAT);
        end
    end

    always @(negedge clk) begin
        check("stall", stall, m_stall());
        check("md_busy", md_busy, m_busy());
        check("fwd_rs_d", fwd_rs_d, m_fwd_d(int'(d_rs)));
        check("fwd_rt_d", fwd_rt_d, m_fwd_d(int'(d_rt)));
        check("fwd_rs_e", fwd_rs_e, m_fwd_e(pipe[0].rs));
        check("fwd_rt_e", fwd_rt_e, m_fwd_e(pipe[0].rt));
        check("fwd_rt_m", fwd_rt_m, m_fwd_m(pipe[1].rt));
    end

    task automatic set_d(bit v, int rs, int rs_tu, int rt, int rt_tu, bit we, int wa,
                         int tn, bit mds, bit mdd, bit hilo);
        d_valid = v; d_rs = AW'(rs); d_rs_tuse = TW'(rs_tu); d_rt = AW'(rt);
        d_rt_tuse = TW'(rt_tu); d_wr_en = we; d_wr_addr = AW'(wa); d_tnew = TW'(tn);
        d_md_start = mds; d_md_div = mdd; d_hilo_use = hilo;
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  n_stall, n_busy;
        bit  hold;

        nop();
        do_reset();
        check("reset_stall", stall, 0);
        check("reset_md_busy", md_busy, 0);

        // ALU -> ALU: addu $3,$1,$2 ; addu $4,$3,$3 ; addu $7,$3,$0
        adv(); set_d(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        adv(); set_d(1, 3, 1, 3, 1, 1, 4, 1, 0, 0, 0);
        check("alu_no_stall", stall, 0);
        adv(); set_d(1, 3, 1, 0, 1, 1, 7, 1, 0, 0, 0);
        check("alu_fwd_rs_e_m", fwd_rs_e, 1);
        check("alu_fwd_rt_e_m", fwd_rt_e, 1);
        check("alu_fwd_rs_d_m", fwd_rs_d, 1);
        adv(); nop();
        check("alu_fwd_rs_e_w", fwd_rs_e, 2);
        check("alu_fwd_rt_m_w", fwd_rt_m, 1);

        // load-use: lw $5 ; beq $5,$0
        do_reset();
        adv(); set_d(1, 1, 1, 0, 3, 1, 5, 2, 0, 0, 0);
        adv(); set_d(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_stall_1", stall, 1);
        adv();
        check("lu_stall_2", stall, 1);
        adv();
        check("lu_stall_done", stall, 0);
        check("lu_fwd_rs_d_w", fwd_rs_d, 2);

        // jal -> jr $31
        do_reset();
        adv(); set_d(1, 0, 3, 0, 3, 1, 31, 0, 0, 0, 0);
        adv(); set_d(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        check("jal_no_stall", stall, 0);
        check("jal_fwd_rs_d_e", fwd_rs_d, 3);
        adv();
        check("jal_fwd_rs_d_m", fwd_rs_d, 1);

        // $0 guard: ori $0 ; addu $6,$0,$0
        do_reset();
        adv(); set_d(1, 1, 1, 0, 3, 1, 0, 1, 0, 0, 0);
        adv(); set_d(1, 0, 1, 0, 1, 1, 6, 1, 0, 0, 0);
        check("zero_stall", stall, 0);
        check("zero_fwd_rs_d", fwd_rs_d, 0);
        check("zero_fwd_rt_d", fwd_rt_d, 0);
        adv(); nop();
        check("zero_fwd_rs_e", fwd_rs_e, 0);
        check("zero_fwd_rt_m", fwd_rt_m, 0);

        // MDU: div then mflo, later mult
        do_reset();
        adv(); set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0);
        check("div_accept_stall", stall, 0);
        adv(); set_d(1, 0, 3, 0, 3, 1, 8, 1, 0, 0, 1);
        n_stall = 0; n_busy = 0;
        for (int i = 0; i < 40 && stall; i++) begin
            if (md_busy) n_busy++;
            n_stall++;
            adv();
        end
        check("div_stall_cycles", n_stall, DIV_LAT);
        check("div_busy_cycles", n_busy, DIV_LAT);
        check("div_busy_clear", md_busy, 0);
        adv(); set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
        adv(); nop();
        n_busy = 0;
        for (int i = 0; i < 40 && md_busy; i++) begin
            n_busy++;
            adv();
        end
        check("mult_busy_cycles", n_busy, MUL_LAT);

        // async reset with lw in M, stall raised and MDU busy
        do_reset();
        adv(); set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
        adv(); set_d(1, 1, 1, 0, 3, 1, 5, 2, 0, 0, 0);
        adv(); set_d(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pre_stall_e", stall, 1);
        adv();
        check("rst_pre_stall_m", stall, 1);
        check("rst_pre_busy", md_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        nop();

        // randomized traffic, D held while the model says it is stalled
        for (int c = 0; c < 3000; c++) begin
            hold = m_stall();
            adv();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            if (!hold)
                set_d($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 99) < 70,
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 99) < 5,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 8);
        end

        adv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
